adc_sample_scheduler: RTL

- Sequences the ADC for up to NUM_REQ requesters; arbitrates their requests round-robin.
- Issues a one-cycle trigger word and waits a fixed conversion latency.
- Captures the measurement and returns it with the requester id over a valid/ready result port.
- Sits between the bus-side peripheral logic and the ADC block, which takes a DATA_WIDTH trigger word and returns a DATA_WIDTH measurement.

---
 rtl/adc_sched_pkg.sv | 20 ++
 rtl/adc_rr_arbiter.sv | 34 +++
 rtl/adc_sample_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared state encoding and trigger-word layout for the ADC sample scheduler
package adc_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TRIG = 3'd1,
      CONV = 3'd2,
      CAPT = 3'd3,
      HOLD = 3'd4
   } state_e;

   localparam int TRIG_START_BIT = 0;
   localparam int TRIG_ID_LSB    = 8;
   localparam int TRIG_ID_W      = 8;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/adc_rr_arbiter.sv
// rtl/adc_rr_arbiter.sv - round-robin arbiter; scan starts at ptr_i and wraps at NUM_REQ
module adc_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (en_i && !found && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            found       = 1'b1;
         end
      end
   end

   assign any_o = found;

endmodule

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - arbitrates ADC sample requests, triggers, waits CONV_CYCLES, returns result
// Optional periodic internal requester enabled by ADC_SCHED_PERIODIC_EN.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REQ      = 4,
   parameter int CONV_CYCLES  = 4
`ifdef ADC_SCHED_PERIODIC_EN
   , parameter int PERIOD_WIDTH = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [DATA_WIDTH-1:0] adc_trigger,
   input  logic [DATA_WIDTH-1:0] adc_measurement,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [7:0]            res_id,
   output logic                  busy
`ifdef ADC_SCHED_PERIODIC_EN
   , input  logic [PERIOD_WIDTH-1:0] period,
   output logic [7:0]            overrun_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_q;
   logic [7:0]       id_q;
   logic [CNT_W-1:0] cnt_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               int_req;
   logic               start;

`ifdef ADC_SCHED_PERIODIC_EN
   logic [PERIOD_WIDTH-1:0] timer_q;
   logic                    pend_q;
   logic [7:0]              ovr_q;
   logic                    wrap;
   logic                    int_grant;

   assign wrap      = (period != '0) && (timer_q >= period - 1'b1);
   assign int_grant = (state_q == IDLE) && pend_q;
   assign int_req   = pend_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= '0;
      end else begin
         if (period == '0 || wrap) timer_q <= '0;
         else                      timer_q <= timer_q + 1'b1;
         pend_q <= wrap | (pend_q & ~int_grant);
         // A wrap that lands while the previous tick is still unserved is lost.
         if (wrap && pend_q && !int_grant && ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
      end
   end

   assign overrun_cnt = ovr_q;
`else
   assign int_req = 1'b0;
`endif

   adc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .en_i  ((state_q == IDLE) && !int_req),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign start = (state_q == IDLE) && (int_req || arb_any);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = TRIG;
         TRIG: state_d = CONV;
         CONV: if (cnt_q == '0) state_d = CAPT;
         CAPT: state_d = HOLD;
         HOLD: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      adc_trigger = '0;
      if (state_q == TRIG) begin
         adc_trigger[TRIG_START_BIT]             = 1'b1;
         adc_trigger[TRIG_ID_LSB +: TRIG_ID_W]   = id_q;
      end
      busy      = (state_q != IDLE);
      // Grant is combinational, so it must also be masked while reset is held.
      req_ready = arb_gnt & {NUM_REQ{reset}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q      <= '0;
         id_q      <= '0;
         cnt_q     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (int_req) begin
                  id_q <= 8'(NUM_REQ);
               end else if (arb_any) begin
                  id_q <= 8'(arb_idx);
                  rr_q <= IDX_W'(rr_next(32'(arb_idx), NUM_REQ));
               end
            end
            TRIG: cnt_q <= CNT_LOAD;
            CONV: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            CAPT: begin
               res_data  <= adc_measurement;
               res_id    <= id_q;
               res_valid <= 1'b1;
            end
            HOLD: if (res_ready) res_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
